// File: rtl/hrm_mbox.sv
// hrm_mbox: NCH independent first-word-fall-through mailbox FIFOs.
// Each channel has a circular buffer of 2**LGFLEN words, occupancy
// status, sticky overflow/underflow flags and a combinational
// "dump" port that can peek at any queued word without popping it.
module hrm_mbox #(
  parameter int DW        = 8,
  parameter int LGFLEN    = 5,
  parameter int NCH       = 2,
  parameter int AFULL_LVL = 28
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic [NCH-1:0]             i_wr,
  input  logic [NCH*DW-1:0]          i_data,
  input  logic [NCH-1:0]             i_rd,
  output logic [NCH*DW-1:0]          o_data,
  output logic [NCH-1:0]             o_empty_n,
  output logic [NCH-1:0]             o_full,
  output logic [NCH-1:0]             o_afull,
  output logic [NCH*(LGFLEN+1)-1:0]  o_level,
  output logic [NCH-1:0]             o_ovf,
  output logic [NCH-1:0]             o_udf,
  input  logic                       i_clr_err,
  input  logic [2:0]                 i_dmp_ch,
  input  logic [LGFLEN-1:0]          i_dmp_pos,
  output logic [DW-1:0]              o_dmp_data,
  output logic                       o_dmp_valid
);

  localparam int DEPTH = 2 ** LGFLEN;
  localparam int LW    = LGFLEN + 1;

  localparam logic [LW-1:0]     LVL_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0]     LVL_AFULL = LW'(AFULL_LVL);
  localparam logic [LW-1:0]     LVL_ONE   = LW'(1);
  localparam logic [LGFLEN-1:0] PTR_ONE   = LGFLEN'(1);

  // Per-channel dump candidates, selected by i_dmp_ch below
  logic [DW-1:0]  dmp_word [NCH];
  logic [NCH-1:0] dmp_hit;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DW-1:0]     mem [DEPTH];
    logic [LGFLEN-1:0] rd_ptr;
    logic [LGFLEN-1:0] wr_ptr;
    logic [LGFLEN-1:0] dmp_addr;
    logic [LW-1:0]     level;
    logic              is_full;
    logic              is_empty;
    logic              push_ok;
    logic              pop_ok;
    logic              ovf_set;
    logic              udf_set;
    logic              ovf;
    logic              udf;

    assign is_full  = (level == LVL_FULL);
    assign is_empty = (level == '0);

    // A full channel still takes a push when a pop frees a slot in the
    // same cycle; an empty channel never honours a pop.
    assign push_ok  = i_wr[c] && (!is_full || i_rd[c]);
    assign pop_ok   = i_rd[c] && !is_empty;
    assign ovf_set  = i_wr[c] && is_full && !i_rd[c];
    assign udf_set  = i_rd[c] && is_empty;

    // Storage write; contents are deliberately left unreset
    always_ff @(posedge clk) begin
      if (i_rst && push_ok) begin
        mem[wr_ptr] <= i_data[c*DW +: DW];
      end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
      if (!i_rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level  <= '0;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop_ok) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        case ({push_ok, pop_ok})
          2'b10:   level <= level + LVL_ONE;
          2'b01:   level <= level - LVL_ONE;
          default: level <= level;
        endcase
      end
    end

    // Sticky error flags; a new error wins over a concurrent clear
    always_ff @(posedge clk) begin
      if (!i_rst) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        if (ovf_set) begin
          ovf <= 1'b1;
        end else if (i_clr_err) begin
          ovf <= 1'b0;
        end
        if (udf_set) begin
          udf <= 1'b1;
        end else if (i_clr_err) begin
          udf <= 1'b0;
        end
      end
    end

    assign o_data[c*DW +: DW]  = mem[rd_ptr];
    assign o_level[c*LW +: LW] = level;
    assign o_empty_n[c]        = !is_empty;
    assign o_full[c]           = is_full;
    assign o_afull[c]          = (level >= LVL_AFULL);
    assign o_ovf[c]            = ovf;
    assign o_udf[c]            = udf;

    assign dmp_addr    = rd_ptr + i_dmp_pos;
    assign dmp_word[c] = mem[dmp_addr];
    assign dmp_hit[c]  = ({1'b0, i_dmp_pos} < level);
  end

  // Dump select: zero data unless the channel exists and the slot is occupied
  always_comb begin
    o_dmp_data  = '0;
    o_dmp_valid = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if ((i_dmp_ch == 3'(c)) && dmp_hit[c]) begin
        o_dmp_data  = dmp_word[c];
        o_dmp_valid = 1'b1;
      end
    end
  end

endmodule

// File: doc/hrm_mbox.md
HRM_MBOX -- requirements
Module: hrm_mbox

Interface
REQ-001 The block SHALL have parameter DW, default 8: data word width in bits.
REQ-002 The block SHALL have parameter LGFLEN, default 5: log2 of per-channel depth, so DEPTH = 2**LGFLEN = 32.
REQ-003 The block SHALL have parameter NCH, default 2, legal range 1..8: number of independent mailbox channels.
REQ-004 The block SHALL have parameter AFULL_LVL, default 28: almost-full threshold, legal range 1..DEPTH.
REQ-005 The block SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 The block SHALL have port i_rst, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have port i_wr, input, NCH bits: per-channel push strobe.
REQ-008 The block SHALL have port i_data, input, NCH*DW bits: per-channel push word; channel c occupies bits [c*DW +: DW].
REQ-009 The block SHALL have port i_rd, input, NCH bits: per-channel pop strobe.
REQ-010 The block SHALL have port o_data, output, NCH*DW bits: per-channel head word, first-word-fall-through.
REQ-011 The block SHALL have port o_empty_n, output, NCH bits: channel holds at least 1 word.
REQ-012 The block SHALL have port o_full, output, NCH bits: channel level == DEPTH.
REQ-013 The block SHALL have port o_afull, output, NCH bits: channel level >= AFULL_LVL.
REQ-014 The block SHALL have port o_level, output, NCH*(LGFLEN+1) bits: per-channel occupancy, 0..DEPTH.
REQ-015 The block SHALL have port o_ovf, output, NCH bits: sticky push-while-full flag.
REQ-016 The block SHALL have port o_udf, output, NCH bits: sticky pop-while-empty flag.
REQ-017 The block SHALL have port i_clr_err, input, 1 bit: clears all o_ovf and o_udf flags.
REQ-018 The block SHALL have port i_dmp_ch, input, 3 bits: channel selected for dump.
REQ-019 The block SHALL have port i_dmp_pos, input, LGFLEN bits: queue position to dump, where 0 = head.
REQ-020 The block SHALL have port o_dmp_data, output, DW bits: word at the selected channel and position.
REQ-021 The block SHALL have port o_dmp_valid, output, 1 bit: the selected position currently holds data.

Function
REQ-022 Each channel SHALL be an independent circular buffer of DEPTH words, with LGFLEN-bit read and write pointers that wrap from DEPTH-1 to 0.
REQ-023 A push SHALL be accepted when i_wr[c]=1 and the channel is not full at the clock edge: the word is stored at the write pointer, the write pointer increments, and the level increments, all effective in the next cycle.
REQ-024 A pop SHALL be accepted when i_rd[c]=1 and the channel is not empty: the read pointer increments and the level decrements in the next cycle.
REQ-025 o_data[c] SHALL combinationally present the word at the read pointer, so a popped word is visible before the pop edge (zero-latency read).
REQ-026 A word pushed into an empty channel SHALL appear on o_data[c] with o_empty_n[c]=1 exactly one cycle after the push edge.
REQ-027 Simultaneous push and pop on a non-empty, non-full channel SHALL both be accepted, leaving the level unchanged.
REQ-028 Simultaneous push and pop on a full channel SHALL both be accepted: level stays DEPTH and o_ovf is not set.
REQ-029 Simultaneous push and pop on an empty channel SHALL accept the push only: level becomes 1 and o_udf[c] is set.
REQ-030 A push to a full channel without a pop SHALL be discarded, leaving memory, pointers and level unchanged, and SHALL set o_ovf[c] in the next cycle.
REQ-031 A pop of an empty channel SHALL leave pointers unchanged and set o_udf[c] in the next cycle.
REQ-032 o_ovf and o_udf SHALL remain set until i_clr_err=1; if i_clr_err coincides with a new error on that channel, the flag SHALL remain set.
REQ-033 o_empty_n, o_full, o_afull and o_level SHALL be derived combinationally from the registered level.
REQ-034 Dump: for i_dmp_ch < NCH and i_dmp_pos < level, o_dmp_valid SHALL be 1 and o_dmp_data SHALL equal the word at (read pointer + i_dmp_pos) mod DEPTH.
REQ-035 For i_dmp_ch >= NCH or i_dmp_pos >= level, o_dmp_valid SHALL be 0 and o_dmp_data SHALL be 0 (never X).
REQ-036 The dump path SHALL be purely combinational and SHALL NOT disturb pointers, level or flags.
REQ-037 Channels SHALL not interact: any activity on channel c leaves every other channel's state unchanged.

Reset
REQ-038 When i_rst=0 at a clock edge, all pointers, levels, o_ovf and o_udf SHALL become 0, so that o_empty_n=0, o_full=0, o_afull=0, o_level=0 and o_dmp_valid=0.
REQ-039 Reset SHALL override any concurrent i_wr, i_rd or i_clr_err in the same cycle.
REQ-040 Storage contents SHALL not be reset, and o_data is don't-care while empty.
REQ-041 Reset asserted mid-operation with a partially filled channel SHALL discard all queued words.

Verification
REQ-042 Reset, then push 0x11,0x22,0x33 on ch0 -> o_level[0]=3, o_data[0]=0x11, ch1 level=0.
REQ-043 Fill ch1 with 32 words 0x00..0x1F -> o_full[1]=1 and o_afull[1]=1 (from level 28); then push 0xAA -> o_ovf[1]=1, level=32, head=0x00.
REQ-044 Pop 0x11 from ch0 while pushing 0x44 in the same cycle -> level stays 3, head=0x22; dump ch0 pos 2 -> 0x44, valid=1; dump pos 3 -> 0x00, valid=0.
REQ-045 Pop an empty ch0 while pushing 0x55 in the same cycle -> level=1, head=0x55 next cycle, o_udf[0]=1; i_clr_err -> o_udf[0]=0.
REQ-046 Run 40 push/pop pairs on ch0 to force pointer wrap -> FIFO order preserved and dump pos 0 equals o_data[0] throughout.
REQ-047 Drive i_rst=0 for one cycle with ch1 full and ch0 holding 3 words -> all levels=0, all flags=0; i_dmp_ch=7 -> valid=0, data=0.
